// File: rtl/seq_detect_fsm.sv
// Serial pattern detector with a programmable pattern, Mealy/Moore output
// selection, overlapping/non-overlapping detection and a saturating match counter.
module seq_detect_fsm #(
  parameter int               PAT_W   = 4,
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] RST_PAT = {PAT_W{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             A,
  input  logic             load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             moore,
  input  logic             overlap,
  input  logic             cnt_clr,
  output logic             Y,
  output logic [CNT_W-1:0] match_cnt,
  output logic             armed
);

  localparam int               FILL_W    = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_ZERO = {FILL_W{1'b0}};
  localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_ARMED = 1'b1
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [PAT_W-2:0]   hist_r, hist_nxt_s, shift_s;
  logic [FILL_W-1:0]  fill_r, fill_nxt_s;
  logic [PAT_W-1:0]   pat_r;
  logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
  logic               flag_r;
  logic               hit_s;

  // History after taking A; a 2-bit pattern keeps only the single newest bit.
  if (PAT_W > 2) begin : g_shift_wide
    assign shift_s = {hist_r[PAT_W-3:0], A};
  end else begin : g_shift_narrow
    assign shift_s = A;
  end

  // A bit completes a match only when consumed, armed, and not discarded by load.
  assign hit_s = en & (state_r == ST_ARMED) & ~load & ({hist_r, A} == pat_r);

  // Next state, fill level and history: load restarts filling, en=0 freezes progress.
  always_comb begin
    state_nxt_s = state_r;
    fill_nxt_s  = fill_r;
    hist_nxt_s  = hist_r;
    if (load) begin
      state_nxt_s = ST_FILL;
      fill_nxt_s  = FILL_ZERO;
    end else if (en) begin
      hist_nxt_s = shift_s;
      case (state_r)
        ST_FILL: begin
          fill_nxt_s = fill_r + FILL_ONE;
          if ((fill_r + FILL_ONE) == FILL_LAST) begin
            state_nxt_s = ST_ARMED;
          end else begin
            state_nxt_s = ST_FILL;
          end
        end
        ST_ARMED: begin
          if (hit_s && !overlap) begin
            // Non-overlapping: the next match needs a full set of fresh bits.
            state_nxt_s = ST_FILL;
            fill_nxt_s  = FILL_ZERO;
          end else begin
            state_nxt_s = ST_ARMED;
            fill_nxt_s  = FILL_LAST;
          end
        end
        default: begin
          state_nxt_s = ST_FILL;
          fill_nxt_s  = FILL_ZERO;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
      fill_nxt_s  = fill_r;
      hist_nxt_s  = hist_r;
    end
  end

  // Match counter: clear wins over a coincident hit; saturate instead of wrapping.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (cnt_clr) begin
      cnt_nxt_s = CNT_ZERO;
    end else if (hit_s && (cnt_r != CNT_MAX)) begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // State, history, pattern, counter and Moore flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_FILL;
      fill_r  <= FILL_ZERO;
      hist_r  <= {(PAT_W-1){1'b0}};
      pat_r   <= RST_PAT;
      cnt_r   <= CNT_ZERO;
      flag_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      fill_r  <= fill_nxt_s;
      hist_r  <= hist_nxt_s;
      pat_r   <= load ? pat_in : pat_r;
      cnt_r   <= cnt_nxt_s;
      // The Moore flag tracks hits every cycle so switching mode never shows stale data.
      flag_r  <= hit_s;
    end
  end

  // Output select: Mealy shows the hit in the completing cycle, Moore one cycle later.
  always_comb begin
    Y = 1'b0;
    if (moore) begin
      Y = flag_r;
    end else begin
      Y = hit_s;
    end
  end

  assign armed     = (state_r == ST_ARMED);
  assign match_cnt = cnt_r;

endmodule

// File: tb/tb_seq_detect_fsm.sv
// Testbench for seq_detect_fsm: three instances (2-bit pattern, 4-bit pattern,
// 4-bit pattern with a 2-bit counter) share stimulus; each step checks one of them.
module tb_seq_detect_fsm;

  logic       clk;
  logic       reset;
  logic       en, a, load, moore, overlap, cnt_clr;
  logic [1:0] pat_in2;
  logic [3:0] pat_in4;
  logic       y2, y4, y4c;
  logic       armed2, armed4, armed4c;
  logic [7:0] cnt2, cnt4;
  logic [1:0] cnt4c;

  // ctl = {en, A, load, moore, overlap, cnt_clr}; ya = {Y, armed} expected before the edge
  typedef struct {
    logic [5:0] ctl;
    logic [1:0] ya;
    logic [7:0] cnt;
    int         dut;
  } vec_t;

  typedef struct {
    int         dut;
    logic [1:0] ya;
    logic [7:0] cnt;
    int         id;
  } exp_t;

  vec_t tbl[$];
  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   step_id = 0;

  seq_detect_fsm #(.PAT_W(2), .CNT_W(8)) u2 (
    .clk(clk), .reset(reset), .en(en), .A(a), .load(load), .pat_in(pat_in2),
    .moore(moore), .overlap(overlap), .cnt_clr(cnt_clr),
    .Y(y2), .match_cnt(cnt2), .armed(armed2)
  );

  seq_detect_fsm #(.PAT_W(4), .CNT_W(8)) u4 (
    .clk(clk), .reset(reset), .en(en), .A(a), .load(load), .pat_in(pat_in4),
    .moore(moore), .overlap(overlap), .cnt_clr(cnt_clr),
    .Y(y4), .match_cnt(cnt4), .armed(armed4)
  );

  seq_detect_fsm #(.PAT_W(4), .CNT_W(2)) u4c (
    .clk(clk), .reset(reset), .en(en), .A(a), .load(load), .pat_in(pat_in4),
    .moore(moore), .overlap(overlap), .cnt_clr(cnt_clr),
    .Y(y4c), .match_cnt(cnt4c), .armed(armed4c)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1);
  end

  function automatic vec_t mk(input logic [5:0] ctl, input logic [1:0] ya,
                              input logic [7:0] cnt, input int dut);
    vec_t v;
    v.ctl = ctl;
    v.ya  = ya;
    v.cnt = cnt;
    v.dut = dut;
    return v;
  endfunction

  // Drive one cycle of stimulus and record what the selected DUT must show.
  task automatic drive(input vec_t v);
    exp_t e;
    {en, a, load, moore, overlap, cnt_clr} = v.ctl;
    e.dut = v.dut;
    e.ya  = v.ya;
    e.cnt = v.cnt;
    e.id  = step_id;
    step_id++;
    sb_q.push_back(e);
  endtask

  // Compare the oldest expectation against the DUT it names.
  task automatic check_front();
    exp_t       e;
    logic [1:0] act_ya;
    logic [7:0] act_cnt;
    n_tests++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard: queue empty, got size 0 required >0");
    end else begin
      e = sb_q.pop_front();
      case (e.dut)
        0:       begin act_ya = {y2, armed2};   act_cnt = cnt2;           end
        1:       begin act_ya = {y4, armed4};   act_cnt = cnt4;           end
        default: begin act_ya = {y4c, armed4c}; act_cnt = {6'b0, cnt4c}; end
      endcase
      if (act_ya !== e.ya || act_cnt !== e.cnt) begin
        n_fail++;
        $display("FAIL step%0d dut%0d: Y/armed/cnt got %b/%b/%0d required %b/%b/%0d",
                 e.id, e.dut, act_ya[1], act_ya[0], act_cnt, e.ya[1], e.ya[0], e.cnt);
      end
    end
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    drive(v);
    #2;
    check_front();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    {en, a, load, moore, overlap, cnt_clr} = 6'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset   = 1'b0;
    {en, a, load, moore, overlap, cnt_clr} = 6'b0;
    pat_in2 = 2'b01;
    pat_in4 = 4'b1010;

    // Reset state of every instance
    #2;
    for (int d = 0; d < 3; d++) begin
      drive(mk(6'b000000, 2'b00, 8'd0, d));
      sb_q[sb_q.size()-1].dut = d;
      check_front();
    end
    @(negedge clk);
    reset = 1'b1;

    // PAT_W=2, pattern 01, stream 0,1,0,0,1,1,0,1: Mealy then Moore
    tbl.push_back(mk(6'b001010, 2'b00, 8'd0, 0));
    tbl.push_back(mk(6'b100010, 2'b00, 8'd0, 0));
    tbl.push_back(mk(6'b110010, 2'b11, 8'd0, 0));
    tbl.push_back(mk(6'b100010, 2'b01, 8'd1, 0));
    tbl.push_back(mk(6'b100010, 2'b01, 8'd1, 0));
    tbl.push_back(mk(6'b110010, 2'b11, 8'd1, 0));
    tbl.push_back(mk(6'b110010, 2'b01, 8'd2, 0));
    tbl.push_back(mk(6'b100010, 2'b01, 8'd2, 0));
    tbl.push_back(mk(6'b110010, 2'b11, 8'd2, 0));
    tbl.push_back(mk(6'b000010, 2'b01, 8'd3, 0));
    tbl.push_back(mk(6'b001111, 2'b01, 8'd3, 0));
    tbl.push_back(mk(6'b100110, 2'b00, 8'd0, 0));
    tbl.push_back(mk(6'b110110, 2'b01, 8'd0, 0));
    tbl.push_back(mk(6'b100110, 2'b11, 8'd1, 0));
    tbl.push_back(mk(6'b100110, 2'b01, 8'd1, 0));
    tbl.push_back(mk(6'b110110, 2'b01, 8'd1, 0));
    tbl.push_back(mk(6'b110110, 2'b11, 8'd2, 0));
    tbl.push_back(mk(6'b100110, 2'b01, 8'd2, 0));
    tbl.push_back(mk(6'b110110, 2'b01, 8'd2, 0));
    tbl.push_back(mk(6'b000110, 2'b11, 8'd3, 0));
    tbl.push_back(mk(6'b000110, 2'b01, 8'd3, 0));
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // PAT_W=4, pattern 1010, stream 1,0,1,0,1,0 overlapping then non-overlapping
    do_reset();
    apply(mk(6'b101010, 2'b00, 8'd0, 1));
    apply(mk(6'b110010, 2'b00, 8'd0, 1));
    apply(mk(6'b100010, 2'b00, 8'd0, 1));
    apply(mk(6'b110010, 2'b00, 8'd0, 1));
    apply(mk(6'b100010, 2'b11, 8'd0, 1));
    apply(mk(6'b110010, 2'b01, 8'd1, 1));
    apply(mk(6'b100010, 2'b11, 8'd1, 1));
    apply(mk(6'b000010, 2'b01, 8'd2, 1));
    apply(mk(6'b101001, 2'b01, 8'd2, 1));
    apply(mk(6'b110000, 2'b00, 8'd0, 1));
    apply(mk(6'b100000, 2'b00, 8'd0, 1));
    apply(mk(6'b110000, 2'b00, 8'd0, 1));
    apply(mk(6'b100000, 2'b11, 8'd0, 1));
    apply(mk(6'b110000, 2'b00, 8'd1, 1));
    apply(mk(6'b100000, 2'b00, 8'd1, 1));
    apply(mk(6'b000000, 2'b00, 8'd1, 1));

    // en=0 freezes progress; load on the completing bit discards it
    do_reset();
    apply(mk(6'b101010, 2'b00, 8'd0, 1));
    apply(mk(6'b110010, 2'b00, 8'd0, 1));
    apply(mk(6'b100010, 2'b00, 8'd0, 1));
    apply(mk(6'b110010, 2'b00, 8'd0, 1));
    for (int i = 0; i < 3; i++) apply(mk(6'b010010, 2'b01, 8'd0, 1));
    apply(mk(6'b100010, 2'b11, 8'd0, 1));
    apply(mk(6'b000010, 2'b01, 8'd1, 1));
    apply(mk(6'b001010, 2'b01, 8'd1, 1));
    apply(mk(6'b110010, 2'b00, 8'd1, 1));
    apply(mk(6'b100010, 2'b00, 8'd1, 1));
    apply(mk(6'b110010, 2'b00, 8'd1, 1));
    for (int i = 0; i < 3; i++) apply(mk(6'b010010, 2'b01, 8'd1, 1));
    apply(mk(6'b101010, 2'b01, 8'd1, 1));
    apply(mk(6'b000010, 2'b00, 8'd1, 1));

    // CNT_W=2: five hits saturate at 3, then cnt_clr beats a coincident hit
    do_reset();
    apply(mk(6'b101010, 2'b00, 8'd0, 2));
    begin
      int hits;
      hits = 0;
      for (int i = 0; i < 12; i++) begin
        logic bit_a, exp_y, exp_armed;
        bit_a     = (i % 2 == 0);
        exp_y     = (i >= 3) && (i % 2 == 1);
        exp_armed = (i >= 3);
        apply(mk({1'b1, bit_a, 4'b0010}, {exp_y, exp_armed}, 8'(hits), 2));
        if (exp_y && hits < 3) hits++;
      end
    end
    apply(mk(6'b110010, 2'b01, 8'd3, 2));
    apply(mk(6'b100011, 2'b11, 8'd3, 2));
    apply(mk(6'b000010, 2'b01, 8'd0, 2));

    // Asynchronous reset between edges while Moore Y is high
    do_reset();
    apply(mk(6'b001110, 2'b00, 8'd0, 0));
    apply(mk(6'b100110, 2'b00, 8'd0, 0));
    apply(mk(6'b110110, 2'b01, 8'd0, 0));
    apply(mk(6'b000110, 2'b11, 8'd1, 0));
    reset = 1'b0;
    #1;
    n_tests++;
    if (y2 !== 1'b0 || armed2 !== 1'b0 || cnt2 !== 8'd0) begin
      n_fail++;
      $display("FAIL async_reset: Y/armed/cnt got %b/%b/%0d required 0/0/0", y2, armed2, cnt2);
    end
    @(negedge clk);
    reset = 1'b1;
    // Restart in FILL with the reset pattern 00 restored
    apply(mk(6'b100010, 2'b00, 8'd0, 0));
    apply(mk(6'b100010, 2'b11, 8'd0, 0));
    apply(mk(6'b000010, 2'b01, 8'd1, 0));

    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d leftover entries required 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
